exec_ctrl: RTL and testbench
============================

# exec_ctrl

Sequencer for the execute stage of the core. Each cycle it decides whether the instruction in execute retires, stalls, redirects fetch, or traps. It owns the load/store memory handshake with a timeout watchdog, branch/jump redirect with target-alignment checking, trap entry, and the WFI sleep state. It sits between decode/execute and the fetch/IO units, and drives the pipeline's stall and flush signals.

## Interface
- `MEM_TIMEOUT`, default 255: maximum cycles in MEM_WAIT before an access fault is raised (1..1023).
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `valid`  in  1  execute holds an instruction.
- `ext_stall`  in  1  downstream (writeback) busy.
- `pc`  in  64  execute-stage PC.
- `load_op`, `store_op`, `wfi_op`  in  1 each  decoded op class.
- `mem_addr`  in  64  effective load/store address.
- `mem_ack`  in  1  IO unit completes the access.
- `bj_en`  in  1  branch taken / jump.
- `bj_pc`  in  64  branch/jump target.
- `exc`  in  1  upstream exception present.
- `cause`  in  5  upstream exception cause.
- `tval`  in  64  upstream exception value.
- `trap_vec`  in  64  trap vector base; bits [1:0] are ignored.
- `irq_pending`  in  1  enabled interrupt pending.
- `stall`  out  1  hold execute and upstream stages.
- `flush`  out  1  kill the younger in-flight instructions.
- `redirect_en`  out  1  fetch redirect strobe.
- `redirect_pc`  out  64  fetch redirect target.
- `mem_req`  out  1  access request to the IO unit.
- `trap_en`  out  1  one-cycle trap-commit strobe.
- `epc_o`, `cause_o`, `tval_o`  out  64 / 5 / 64  registered trap record.
- `sleeping`  out  1  core is in SLEEP.
- `sleep_cycles`  out  32  saturating count of cycles spent in SLEEP.

## Operation
- States: RUN, MEM_WAIT, SLEEP.
- If `ext_stall` is high: `stall`=1 and every other strobe is 0. State, counters and `mem_req` are held. The watchdog does not count.
- RUN with `valid` set, one action per cycle, evaluated in this priority order:
  1. `exc`: trap with the upstream `cause` and `tval`.
  2. `bj_en` with `bj_pc[1:0]` != 0: trap with cause 0 and tval = `bj_pc`.
  3. `bj_en`: `redirect_en`=1, `redirect_pc`=`bj_pc`, `flush`=1.
  4. `load_op` or `store_op`: `mem_req`=1 and `stall`=~`mem_ack`. If `mem_ack` is low, go to MEM_WAIT.
  5. `wfi_op`: if `irq_pending` is high, retire as a NOP. Otherwise `stall`=1 and go to SLEEP.
- A trap means, in the same cycle: `trap_en`=1, `flush`=1, `redirect_en`=1, `redirect_pc`={`trap_vec`[63:2],2'b00}. On the next edge, `epc_o`, `cause_o` and `tval_o` capture the new record.
- MEM_WAIT:
  - `mem_req`=1 and `stall`=1 until `mem_ack`.
  - On `mem_ack`: `stall`=0 that cycle and go to RUN.
  - The watchdog counts cycles in MEM_WAIT. If it reaches `MEM_TIMEOUT` with no ack, take a trap: cause 5 for a load, 7 for a store, tval = `mem_addr`. Then drop `mem_req` and go to RUN.
  - If `mem_ack` arrives on the timeout cycle, the ack wins and no trap is taken.
- SLEEP:
  - `sleeping`=1 and `stall`=1.
  - `sleep_cycles` increments every SLEEP cycle and saturates at 2^32-1.
  - `irq_pending` is sampled every cycle. When it is high, the WFI retires in that cycle (`stall`=0) and the state goes to RUN.
- `valid`=0 in RUN: all strobes are 0.

## Timing
- Redirect, flush, trap and stall decisions are combinational from the current state and inputs (zero-latency). The trap record and `sleep_cycles` are registered (one-cycle latency).
- A memory access acked in its issue cycle costs 0 stall cycles. An access acked N cycles later costs N stall cycles.
- Reset (including mid-MEM_WAIT or mid-SLEEP):
  - State returns to RUN.
  - `mem_req` is dropped in the reset cycle; the IO unit must discard the pending request.
  - All outputs are 0: `stall`, `flush`, `redirect_en`, `redirect_pc`, `mem_req`, `trap_en`, `epc_o`, `cause_o`, `tval_o`, `sleeping`, `sleep_cycles`.
  - The watchdog is cleared.

## Structure
- Shared package `exec_ctrl_pkg`:
  - `exec_state_t` enum (RUN, MEM_WAIT, SLEEP).
  - Cause constants `CAUSE_INSN_MISALIGN`=0, `CAUSE_LOAD_FAULT`=5, `CAUSE_STORE_FAULT`=7.
- Sub-module `mem_watchdog`, a 10-bit counter:
  - Inputs: clear, enable.
  - Output: `expired` when the count equals `MEM_TIMEOUT`.
- The rest of the block is a single FSM plus output muxing.

## Test plan
- Load at pc 0x80000010 with `mem_ack` 3 cycles after issue: `mem_req` high for 4 cycles, `stall`=1,1,1,0, no trap.
- Jump with `bj_pc`=0x80000102: `trap_en`=1, `redirect_pc`=`trap_vec`&~3. Next cycle `epc_o`=pc, `cause_o`=0, `tval_o`=0x80000102. With `bj_pc`=0x80000100 instead: redirect only, `flush`=1, no trap.
- Store with no ack and `MEM_TIMEOUT`=8, `mem_addr`=0x10001000: trap after 8 wait cycles with `cause_o`=7, `tval_o`=0x10001000, `mem_req` low afterwards. Repeat with the ack arriving on cycle 8: no trap.
- WFI with `irq_pending` low, raised 5 cycles later: `sleeping` high for 5 cycles, `sleep_cycles`=5, WFI retires on the irq cycle. WFI with `irq_pending` already high: 0 stall cycles.
- `exc`=1 (cause 2) together with `bj_en`=1: the exception wins, `redirect_pc` is the trap vector, `cause_o`=2.
- `rst` pulsed mid-MEM_WAIT and mid-SLEEP: the next cycle shows state RUN, every output 0, `sleep_cycles`=0. `ext_stall` held for 4 cycles in MEM_WAIT does not advance the watchdog.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the execute-stage sequencer.
package exec_ctrl_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned CAUSE_W = 5;
    localparam int unsigned WD_W    = 10;
    localparam int unsigned SLP_W   = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        SLEEP    = 2'd2
    } exec_state_t;

    localparam logic [CAUSE_W-1:0] CAUSE_INSN_MISALIGN = CAUSE_W'(0);
    localparam logic [CAUSE_W-1:0] CAUSE_LOAD_FAULT    = CAUSE_W'(5);
    localparam logic [CAUSE_W-1:0] CAUSE_STORE_FAULT   = CAUSE_W'(7);

    typedef struct packed {
        logic [XLEN-1:0]    epc;
        logic [CAUSE_W-1:0] cause;
        logic [XLEN-1:0]    tval;
    } trap_rec_t;

    // Trap entry is always word aligned; the low two vector bits are mode bits.
    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] vec);
        return vec & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Execute-stage control bus between decode/execute, the sequencer and fetch/IO.
interface exec_ctrl_if;
    import exec_ctrl_pkg::*;

    logic                valid;
    logic                ext_stall;
    logic [XLEN-1:0]     pc;
    logic                load_op;
    logic                store_op;
    logic                wfi_op;
    logic [XLEN-1:0]     mem_addr;
    logic                mem_ack;
    logic                bj_en;
    logic [XLEN-1:0]     bj_pc;
    logic                exc;
    logic [CAUSE_W-1:0]  cause;
    logic [XLEN-1:0]     tval;
    logic [XLEN-1:0]     trap_vec;
    logic                irq_pending;

    logic                stall;
    logic                flush;
    logic                redirect_en;
    logic [XLEN-1:0]     redirect_pc;
    logic                mem_req;
    logic                trap_en;
    logic [XLEN-1:0]     epc_o;
    logic [CAUSE_W-1:0]  cause_o;
    logic [XLEN-1:0]     tval_o;
    logic                sleeping;
    logic [SLP_W-1:0]    sleep_cycles;

    modport slave (
        input  valid, ext_stall, pc, load_op, store_op, wfi_op, mem_addr, mem_ack,
               bj_en, bj_pc, exc, cause, tval, trap_vec, irq_pending,
        output stall, flush, redirect_en, redirect_pc, mem_req, trap_en,
               epc_o, cause_o, tval_o, sleeping, sleep_cycles
    );

    modport master (
        output valid, ext_stall, pc, load_op, store_op, wfi_op, mem_addr, mem_ack,
               bj_en, bj_pc, exc, cause, tval, trap_vec, irq_pending,
        input  stall, flush, redirect_en, redirect_pc, mem_req, trap_en,
               epc_o, cause_o, tval_o, sleeping, sleep_cycles
    );

endinterface

// File: rtl/exec_ctrl_mem_watchdog.sv
// Counts memory-wait cycles; expired is registered and true once the count hits MEM_TIMEOUT.
module mem_watchdog
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WD_W-1:0] count;
    logic [WD_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (enable && (count != WD_W'(MEM_TIMEOUT))) begin
            count_nxt = count + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_nxt;
            expired <= (count_nxt == WD_W'(MEM_TIMEOUT));
        end
    end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage sequencer: retire/stall/redirect/trap decisions, memory wait with watchdog, WFI sleep.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic        clk,
    input logic        rst,
    exec_ctrl_if.slave bus
);

    exec_state_t        state;
    exec_state_t        state_nxt;
    logic               stall_c;
    logic               flush_c;
    logic               redir_c;
    logic [XLEN-1:0]    rpc_c;
    logic               mreq_c;
    logic               trap_c;
    logic               sleeping_c;
    logic [CAUSE_W-1:0] tcause_c;
    logic [XLEN-1:0]    ttval_c;
    logic               wd_en;
    logic               wd_clr;
    logic               wd_expired;
    logic               mem_is_store;
    trap_rec_t          trap_rec;
    logic [SLP_W-1:0]   sleep_cnt;

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clr),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next state and zero-latency pipeline controls.
    always_comb begin
        state_nxt  = state;
        stall_c    = 1'b0;
        flush_c    = 1'b0;
        redir_c    = 1'b0;
        rpc_c      = '0;
        mreq_c     = 1'b0;
        trap_c     = 1'b0;
        sleeping_c = 1'b0;
        tcause_c   = '0;
        ttval_c    = '0;
        if (rst) begin
            state_nxt = RUN;
        end else if (bus.ext_stall) begin
            stall_c    = 1'b1;
            mreq_c     = (state == MEM_WAIT);
            sleeping_c = (state == SLEEP);
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.valid) begin
                        if (bus.exc) begin
                            trap_c   = 1'b1;
                            tcause_c = bus.cause;
                            ttval_c  = bus.tval;
                        end else if (bus.bj_en && (bus.bj_pc[1:0] != 2'b00)) begin
                            trap_c   = 1'b1;
                            tcause_c = CAUSE_INSN_MISALIGN;
                            ttval_c  = bus.bj_pc;
                        end else if (bus.bj_en) begin
                            redir_c = 1'b1;
                            rpc_c   = bus.bj_pc;
                            flush_c = 1'b1;
                        end else if (bus.load_op || bus.store_op) begin
                            mreq_c  = 1'b1;
                            stall_c = ~bus.mem_ack;
                            if (!bus.mem_ack) state_nxt = MEM_WAIT;
                        end else if (bus.wfi_op && !bus.irq_pending) begin
                            stall_c   = 1'b1;
                            state_nxt = SLEEP;
                        end
                    end
                end
                MEM_WAIT: begin
                    mreq_c = 1'b1;
                    if (bus.mem_ack) begin
                        state_nxt = RUN;
                    end else if (wd_expired) begin
                        trap_c    = 1'b1;
                        tcause_c  = mem_is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                        ttval_c   = bus.mem_addr;
                        state_nxt = RUN;
                    end else begin
                        stall_c = 1'b1;
                    end
                end
                SLEEP: begin
                    sleeping_c = 1'b1;
                    if (bus.irq_pending) state_nxt = RUN;
                    else                 stall_c   = 1'b1;
                end
                default: state_nxt = RUN;
            endcase
            if (trap_c) begin
                flush_c = 1'b1;
                redir_c = 1'b1;
                rpc_c   = trap_target(bus.trap_vec);
            end
        end
    end

    // Watchdog runs across the issue edge so the Nth wait cycle sees count N.
    assign wd_en  = !rst && !bus.ext_stall && (state_nxt == MEM_WAIT);
    assign wd_clr = !bus.ext_stall && (state_nxt != MEM_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_is_store <= 1'b0;
            trap_rec     <= '0;
            sleep_cnt    <= '0;
        end else begin
            if ((state == RUN) && (state_nxt == MEM_WAIT)) mem_is_store <= bus.store_op;
            if (trap_c) trap_rec <= '{epc: bus.pc, cause: tcause_c, tval: ttval_c};
            if ((state == SLEEP) && !bus.ext_stall && (sleep_cnt != '1)) begin
                sleep_cnt <= sleep_cnt + SLP_W'(1);
            end
        end
    end

    assign bus.stall        = stall_c;
    assign bus.flush        = flush_c;
    assign bus.redirect_en  = redir_c;
    assign bus.redirect_pc  = rpc_c;
    assign bus.mem_req      = mreq_c;
    assign bus.trap_en      = trap_c;
    assign bus.sleeping     = sleeping_c;
    assign bus.epc_o        = trap_rec.epc;
    assign bus.cause_o      = trap_rec.cause;
    assign bus.tval_o       = trap_rec.tval;
    assign bus.sleep_cycles = sleep_cnt;

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: vector table, directed multi-cycle sequences, random vs model.
module tb_exec_ctrl;
    import exec_ctrl_pkg::*;

    localparam int unsigned TO  = 8;
    localparam logic [63:0] PC0 = 64'h0000_0000_8000_0040;
    localparam logic [63:0] TV  = 64'h0000_0000_8000_1003;
    localparam logic [63:0] TVA = 64'h0000_0000_8000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exec_ctrl_if bus ();
    exec_ctrl #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [63:0] r_epc;
    logic [63:0] r_tval;
    logic [4:0]  r_cause;

    // ctl = {valid, ext_stall, exc, bj_en, load, store, wfi, ack, irq}
    // flags = {stall, flush, redirect_en, mem_req, trap_en, sleeping}
    typedef struct {
        logic [8:0]  ctl;
        logic [4:0]  cause;
        logic [63:0] tval;
        logic [63:0] bj_pc;
        logic [5:0]  flags;
        logic [63:0] rpc;
        logic [4:0]  ecause;
        logic [63:0] etval;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] dut_flags();
        return {bus.stall, bus.flush, bus.redirect_en, bus.mem_req, bus.trap_en, bus.sleeping};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_in();
        bus.valid = 1'b0; bus.ext_stall = 1'b0; bus.pc = PC0;
        bus.load_op = 1'b0; bus.store_op = 1'b0; bus.wfi_op = 1'b0;
        bus.mem_addr = '0; bus.mem_ack = 1'b0; bus.bj_en = 1'b0; bus.bj_pc = '0;
        bus.exc = 1'b0; bus.cause = '0; bus.tval = '0; bus.trap_vec = TV;
        bus.irq_pending = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [5:0] flags, input logic [63:0] rpc);
        chk({name, "_flags"}, 64'(dut_flags()), 64'(flags));
        chk({name, "_rpc"}, bus.redirect_pc, rpc);
    endtask

    task automatic chk_rec(input string name);
        chk({name, "_epc"}, bus.epc_o, r_epc);
        chk({name, "_cause"}, 64'(bus.cause_o), 64'(r_cause));
        chk({name, "_tval"}, bus.tval_o, r_tval);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        settle();
        chk_out({name, "_in_rst"}, 6'b000000, 64'h0);
        tick();
        rst = 1'b0;
        idle_in();
        r_epc = '0; r_cause = '0; r_tval = '0;
        settle();
        chk_out({name, "_after_rst"}, 6'b000000, 64'h0);
        chk_rec(name);
        chk({name, "_slp"}, 64'(bus.sleep_cycles), 64'h0);
    endtask

    // Memory access issued at cycle 0; per-cycle ext_stall mask and ack cycle; expect trap at trap_at (-1: none).
    task automatic mem_seq(input string name, input logic st, input int n, input int ack_at,
                           input int trap_at, input int xs_lo, input int xs_hi);
        int waited;
        waited = 0;
        bus.valid = 1'b1; bus.pc = 64'h0000_0000_8000_0010;
        bus.load_op = ~st; bus.store_op = st; bus.mem_addr = 64'h0000_0000_1000_1000;
        for (int i = 0; i < n; i++) begin
            bus.ext_stall = (i >= xs_lo) && (i <= xs_hi);
            bus.mem_ack = (i == ack_at);
            settle();
            if (bus.ext_stall) chk_out(name, 6'b100100, 64'h0);
            else if (i == trap_at) chk_out(name, 6'b011110, TVA);
            else if (i == ack_at) chk_out(name, 6'b000100, 64'h0);
            else chk_out(name, 6'b100100, 64'h0);
            tick();
        end
        if (trap_at >= 0) begin
            r_epc = bus.pc; r_cause = st ? 5'd7 : 5'd5; r_tval = bus.mem_addr;
        end
        bus.valid = 1'b0; bus.ext_stall = 1'b0; bus.mem_ack = 1'b0;
        settle();
        chk_out({name, "_after"}, 6'b000000, 64'h0);
        chk_rec(name);
        waited = n;
    endtask

    // Reference model state
    logic        m_wait, m_sleep, m_wst;
    int          m_wn;
    logic [31:0] m_slp;

    initial begin
        logic [5:0]  ef;
        logic [63:0] erpc, bj;
        logic        trap;
        logic [4:0]  tc;
        logic [63:0] tv;

        idle_in();
        rst = 1'b1;
        tick();
        settle();
        r_epc = '0; r_cause = '0; r_tval = '0;
        chk_out("reset", 6'b000000, 64'h0);
        chk_rec("reset");
        chk("reset_slp", 64'(bus.sleep_cycles), 64'h0);
        rst = 1'b0;

        vecs[0]  = '{9'b0_0_1_1_1_1_1_0_0, 5'd2, 64'h11,   64'h8000_0102, 6'b000000, 64'h0,          5'd0, 64'h0};
        vecs[1]  = '{9'b1_0_1_1_0_0_0_0_0, 5'd2, 64'hDEAD, 64'h8000_0100, 6'b011010, TVA,            5'd2, 64'hDEAD};
        vecs[2]  = '{9'b1_0_0_1_0_0_0_0_0, 5'd0, 64'h0,    64'h8000_0102, 6'b011010, TVA,            5'd0, 64'h8000_0102};
        vecs[3]  = '{9'b1_0_0_1_0_0_0_0_0, 5'd0, 64'h0,    64'h8000_0100, 6'b011000, 64'h8000_0100,  5'd0, 64'h0};
        vecs[4]  = '{9'b1_0_0_1_1_0_0_1_0, 5'd0, 64'h0,    64'h8000_0201, 6'b011010, TVA,            5'd0, 64'h8000_0201};
        vecs[5]  = '{9'b1_0_0_0_1_0_0_1_0, 5'd0, 64'h0,    64'h0,         6'b000100, 64'h0,          5'd0, 64'h0};
        vecs[6]  = '{9'b1_0_0_0_0_1_1_1_0, 5'd0, 64'h0,    64'h0,         6'b000100, 64'h0,          5'd0, 64'h0};
        vecs[7]  = '{9'b1_0_0_0_0_0_1_0_1, 5'd0, 64'h0,    64'h0,         6'b000000, 64'h0,          5'd0, 64'h0};
        vecs[8]  = '{9'b1_1_1_1_1_0_0_0_0, 5'd4, 64'h77,   64'h8000_0103, 6'b100000, 64'h0,          5'd0, 64'h0};
        vecs[9]  = '{9'b1_0_1_0_1_0_0_1_0, 5'd3, 64'h1234, 64'h0,         6'b011010, TVA,            5'd3, 64'h1234};
        vecs[10] = '{9'b1_0_0_1_1_0_0_1_0, 5'd0, 64'h0,    64'h8000_0104, 6'b011000, 64'h8000_0104,  5'd0, 64'h0};
        vecs[11] = '{9'b0_1_0_0_0_0_0_0_0, 5'd0, 64'h0,    64'h0,         6'b100000, 64'h0,          5'd0, 64'h0};

        for (int i = 0; i < 12; i++) begin
            {bus.valid, bus.ext_stall, bus.exc, bus.bj_en, bus.load_op, bus.store_op,
             bus.wfi_op, bus.mem_ack, bus.irq_pending} = vecs[i].ctl;
            bus.cause = vecs[i].cause; bus.tval = vecs[i].tval; bus.bj_pc = vecs[i].bj_pc;
            settle();
            chk_out($sformatf("vec%0d", i), vecs[i].flags, vecs[i].rpc);
            tick();
            if (vecs[i].flags[1]) begin
                r_epc = PC0; r_cause = vecs[i].ecause; r_tval = vecs[i].etval;
            end
            chk_rec($sformatf("vec%0d", i));
            idle_in();
        end

        // Load acked three cycles after issue
        do_reset("ld3");
        mem_seq("ld3", 1'b0, 4, 3, -1, 99, 99);
        // Store timeout, then ack exactly on the timeout cycle
        do_reset("st_to");
        mem_seq("st_to", 1'b1, 9, -1, 8, 99, 99);
        do_reset("st_ack8");
        mem_seq("st_ack8", 1'b1, 9, 8, -1, 99, 99);
        // Four ext_stall cycles inside MEM_WAIT do not advance the watchdog
        do_reset("ld_xs");
        mem_seq("ld_xs", 1'b0, 13, -1, 12, 3, 6);

        // WFI sleeping five cycles
        do_reset("wfi");
        bus.valid = 1'b1; bus.wfi_op = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.irq_pending = (i == 5);
            settle();
            if (i == 0)      chk_out("wfi", 6'b100000, 64'h0);
            else if (i == 5) chk_out("wfi", 6'b000001, 64'h0);
            else             chk_out("wfi", 6'b100001, 64'h0);
            tick();
        end
        bus.irq_pending = 1'b1;
        settle();
        chk_out("wfi_irq_hi", 6'b000000, 64'h0);
        chk("wfi_slp", 64'(bus.sleep_cycles), 64'h5);
        tick();
        chk("wfi_slp_hold", 64'(bus.sleep_cycles), 64'h5);
        idle_in();

        // Reset mid-MEM_WAIT; afterwards RUN behaviour (redirect) is visible
        do_reset("rst_mw");
        bus.valid = 1'b1; bus.load_op = 1'b1;
        tick(); tick();
        settle();
        chk_out("rst_mw_pre", 6'b100100, 64'h0);
        do_reset("rst_mw");
        bus.valid = 1'b1; bus.bj_en = 1'b1; bus.bj_pc = 64'h8000_0200;
        settle();
        chk_out("rst_mw_run", 6'b011000, 64'h8000_0200);
        tick();
        idle_in();

        // Reset mid-SLEEP clears sleep_cycles
        bus.valid = 1'b1; bus.wfi_op = 1'b1;
        tick(); tick();
        settle();
        chk("rst_sl_pre", 64'(bus.sleep_cycles), 64'h1);
        do_reset("rst_sl");

        // Random stimulus against the reference model
        m_wait = 1'b0; m_sleep = 1'b0; m_wst = 1'b0; m_wn = 0; m_slp = '0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.ext_stall = ($urandom_range(0, 7) == 0);
            bus.valid = ($urandom_range(0, 3) != 0);
            bus.exc = ($urandom_range(0, 7) == 0);
            bus.bj_en = ($urandom_range(0, 3) == 0);
            bus.load_op = ($urandom_range(0, 2) == 0);
            bus.store_op = ($urandom_range(0, 3) == 0);
            bus.wfi_op = ($urandom_range(0, 3) == 0);
            bus.mem_ack = ($urandom_range(0, 5) == 0);
            bus.irq_pending = ($urandom_range(0, 3) == 0);
            bus.cause = 5'($urandom);
            bus.tval = {$urandom, $urandom};
            bus.pc = {$urandom, $urandom};
            bus.mem_addr = {$urandom, $urandom};
            bus.trap_vec = {$urandom, $urandom};
            bj = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) bj[1:0] = 2'b00;
            bus.bj_pc = bj;

            ef = '0; erpc = '0; trap = 1'b0; tc = '0; tv = '0;
            if (rst) begin
                m_wait = 1'b0; m_sleep = 1'b0; m_wn = 0; m_slp = '0;
            end else if (bus.ext_stall) begin
                ef = {1'b1, 2'b00, m_wait, 1'b0, m_sleep};
            end else if (m_wait) begin
                ef[2] = 1'b1;
                if (bus.mem_ack) begin
                    m_wait = 1'b0;
                end else if (m_wn + 1 == int'(TO)) begin
                    trap = 1'b1; tc = m_wst ? 5'd7 : 5'd5; tv = bus.mem_addr; m_wait = 1'b0;
                end else begin
                    ef[5] = 1'b1; m_wn++;
                end
            end else if (m_sleep) begin
                ef[0] = 1'b1;
                if (m_slp != 32'hFFFF_FFFF) m_slp++;
                if (bus.irq_pending) m_sleep = 1'b0;
                else                 ef[5] = 1'b1;
            end else if (bus.valid) begin
                if (bus.exc) begin
                    trap = 1'b1; tc = bus.cause; tv = bus.tval;
                end else if (bus.bj_en && (bus.bj_pc % 4 != 0)) begin
                    trap = 1'b1; tc = 5'd0; tv = bus.bj_pc;
                end else if (bus.bj_en) begin
                    ef[4] = 1'b1; ef[3] = 1'b1; erpc = bus.bj_pc;
                end else if (bus.load_op || bus.store_op) begin
                    ef[2] = 1'b1;
                    if (!bus.mem_ack) begin
                        ef[5] = 1'b1; m_wait = 1'b1; m_wn = 0; m_wst = bus.store_op;
                    end
                end else if (bus.wfi_op && !bus.irq_pending) begin
                    ef[5] = 1'b1; m_sleep = 1'b1;
                end
            end
            if (trap) begin
                ef[4] = 1'b1; ef[3] = 1'b1; ef[1] = 1'b1;
                erpc = bus.trap_vec - (bus.trap_vec % 4);
            end
            settle();
            chk_out("rnd", ef, erpc);
            tick();
            if (rst) begin
                r_epc = '0; r_cause = '0; r_tval = '0;
            end else if (trap) begin
                r_epc = bus.pc; r_cause = tc; r_tval = tv;
            end
            chk_rec("rnd");
            chk("rnd_slp", 64'(bus.sleep_cycles), 64'(m_slp));
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
